instr_stream_tx: RTL and testbench
==================================

// Module: instr_stream_tx
// PURPOSE
//  Host-side feeder for the 8-bit mini RISC core. Buffers 16-bit instructions in a FIFO.
//  Serializes each one into the core's two-phase byte load protocol: low byte on ui with
//  bit7 as the load strobe, then high byte on uio. Gives the core an execute cycle, then
//  captures the core's result (uo) and debug bus (uio_out = {pc[4:0], rd}) for the host.
// PARAMETERS
//  DEPTH  4  FIFO entries; must be a power of 2 and at least 2
// PORTS
//  clk         in   1   clock; same clock as the core
//  rst         in   1   asynchronous reset, active-high; the core shares it
//  in_instr    in   16  instruction to transmit
//  in_valid    in   1   in_instr is valid
//  in_ready    out  1   FIFO not full; a push occurs when in_valid && in_ready
//  core_ui     out  8   drives core ui_in
//  core_uio    out  8   drives core uio_in
//  core_uo     in   8   from core uo_out
//  core_dbg    in   8   from core uio_out; [7:3] = pc[4:0], [2:0] = current_rd
//  res_data    out  8   captured core_uo
//  res_rd      out  3   captured core_dbg[2:0]
//  res_pc      out  5   captured core_dbg[7:3]
//  res_valid   out  1   1-cycle pulse; res_* valid in that cycle
//  busy        out  1   1 when state != IDLE or FIFO not empty
//  fifo_count  out  $clog2(DEPTH)+1   number of occupied entries
//  clr_err     in   1   synchronous clear of sticky error flags
//  err_bit7    out  1   sticky: an instruction with instr[7]=0 was dropped
//  err_seq     out  1   sticky PC sequence error (tied 0 without SEQ_CHECK_EN)
// BEHAVIOUR
//  Reset values: all outputs 0, in_ready=1, FIFO empty, state IDLE, exp_pc=0.
//  FIFO: pop happens only in IDLE. No push bypass when full. Push and pop in the same
//   cycle leave fifo_count unchanged.
//  Constraint: the core treats ui[7] as both load strobe and instr bit 7, so instr[7]
//   must be 1.
//  FSM (one cycle per state except IDLE):
//   IDLE:  FIFO empty -> stay, core_ui=0, core_uio=0.
//          Head has instr[7]=0 -> pop, set err_bit7, stay in IDLE. Nothing is sent.
//          Otherwise -> pop into a hold register, go to LO.
//   LO:    core_ui={1'b1, instr[6:0]}, core_uio=0 -> HI
//   HI:    core_ui=8'h80, core_uio=instr[15:8] -> EXEC
//   EXEC:  core_ui=8'h00. The core executes at the end of this cycle -> CAPT
//   CAPT:  core_ui=8'h00. At the clock edge, sample core_uo and core_dbg into res_*.
//          res_valid=1 in the next cycle -> IDLE
//  Latency: pop to res_valid is 5 cycles. Peak throughput is one instruction per
//   5 cycles.
//  core_ui[7] is never high for two consecutive pairs without an EXEC cycle between
//   them, which keeps the core's load phase aligned.
//  Reset mid-operation clears the FIFO and returns to IDLE. No res_valid is produced
//   for the aborted instruction. Because the core shares rst, phase alignment is kept.
//  clr_err has priority over a same-cycle error set: the flag reads 0 the next cycle.
// CONFIGURATION
//  SEQ_CHECK_EN defined:
//   - In CAPT, for opcodes other than 2'b11, compare core_dbg[7:3] with exp_pc+1
//     (5-bit, wraps 31->0).
//   - On mismatch, set err_seq.
//   - exp_pc is then loaded with the observed pc, for every opcode.
//  SEQ_CHECK_EN undefined: no exp_pc register; err_seq is tied to 0.
// TESTING
//  Reset: rst pulse -> all outputs 0 and in_ready=1 the next cycle.
//  Single ADDI: push 16'h0585 (r1 = r4 + 5) -> core_ui 85, 80, 00, 00 on consecutive
//   cycles with core_uio=05 in the HI cycle; then res_valid with res_data=05,
//   res_rd=1, res_pc=1.
//  Drop: push 16'h0505 -> err_bit7=1, core_ui stays 00, no res_valid.
//   Then clr_err -> err_bit7=0.
//  Burst: push 5 valid instructions back-to-back (DEPTH=4) -> in_ready drops only while
//   fifo_count=4. res_valid pulses are exactly 5 cycles apart; res_pc = 1,2,3,4,5.
//  Reset during HI: assert rst -> core_ui=00 and fifo_count=0.
//   Re-push 16'h0585 -> correct result, res_pc=1.
//  SEQ_CHECK_EN: stub core_dbg to report pc=3 for the first R-type -> err_seq=1.
//   A second instruction reporting pc=4 -> no new error.

Source files
------------

// File: rtl/instr_stream_tx.sv
// instr_stream_tx
//   Host-side feeder for the 8-bit mini RISC core. 16-bit instructions are
//   queued in a small FIFO. Each one is sent to the core as two byte loads:
//   first the low byte on core_ui, whose bit 7 is the load strobe, then the
//   high byte on core_uio. The core then gets one execute cycle. After that
//   its result (core_uo) and debug bus (core_dbg) are captured for the host.
//
// Parameters
//   DEPTH       FIFO entries (power of 2, >= 2)
// Ports
//   clk, rst    clock; asynchronous active-high reset (shared with the core)
//   in_instr/in_valid/in_ready   instruction push interface
//   core_ui/core_uio             byte lanes into the core (registered)
//   core_uo/core_dbg             core result and {pc[4:0], rd[2:0]}
//   res_data/res_rd/res_pc/res_valid   captured result, res_valid is a 1-cycle pulse
//   busy, fifo_count             activity and occupancy status
//   clr_err, err_bit7, err_seq   sticky error flags and their synchronous clear
// Optional feature
//   `define SEQ_CHECK_EN enables the PC sequence check that drives err_seq.
//   Without it err_seq is tied to 0 and no expected-PC register exists.
module instr_stream_tx #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              in_instr,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [7:0]               core_ui,
    output logic [7:0]               core_uio,
    input  logic [7:0]               core_uo,
    input  logic [7:0]               core_dbg,
    output logic [7:0]               res_data,
    output logic [2:0]               res_rd,
    output logic [4:0]               res_pc,
    output logic                     res_valid,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    input  logic                     clr_err,
    output logic                     err_bit7,
    output logic                     err_seq
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL    = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;

    typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_EXEC, S_CAPT} state_t;

    // FIFO storage (not reset; only entries between the pointers are meaningful)
    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;

    state_t        state_q;
    logic [7:0]    hold_hi_q;      // high byte of the instruction in flight
    logic [7:0]    core_ui_q, core_uio_q;
    logic [7:0]    res_data_q;
    logic [2:0]    res_rd_q;
    logic [4:0]    res_pc_q;
    logic          res_valid_q;
    logic          err_bit7_q;

    logic [15:0]   head;
    logic          push, pop, drop;

    assign head = mem_q[rd_ptr_q];
    assign push = in_valid && in_ready;
    // Pops only happen in IDLE. A head with bit 7 clear is popped and discarded.
    assign pop  = (state_q == S_IDLE) && (count_q != '0);
    assign drop = pop && !head[7];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_instr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
        end
    end

    // Sequencer. core_ui/core_uio are loaded on entry to each state, so the
    // registered lanes always match the current state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hold_hi_q   <= '0;
            core_ui_q   <= '0;
            core_uio_q  <= '0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
            res_pc_q    <= '0;
            res_valid_q <= 1'b0;
            err_bit7_q  <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    core_ui_q  <= 8'h00;
                    core_uio_q <= 8'h00;
                    if (pop && head[7]) begin
                        hold_hi_q <= head[15:8];
                        core_ui_q <= {1'b1, head[6:0]};
                        state_q   <= S_LO;
                    end
                end
                S_LO: begin
                    // bit 7 stays high: the second byte of the load pair
                    core_ui_q  <= 8'h80;
                    core_uio_q <= hold_hi_q;
                    state_q    <= S_HI;
                end
                S_HI: begin
                    core_ui_q  <= 8'h00;
                    core_uio_q <= 8'h00;
                    state_q    <= S_EXEC;
                end
                S_EXEC: begin
                    state_q <= S_CAPT;
                end
                S_CAPT: begin
                    res_data_q  <= core_uo;
                    res_rd_q    <= core_dbg[2:0];
                    res_pc_q    <= core_dbg[7:3];
                    res_valid_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            // clear wins over a same-cycle set
            if (clr_err)   err_bit7_q <= 1'b0;
            else if (drop) err_bit7_q <= 1'b1;
        end
    end

`ifdef SEQ_CHECK_EN
    // The opcode is taken from instr[1:0]. Opcode 2'b11 (control flow) may
    // legitimately move the PC anywhere, so it is exempt from the check.
    logic [1:0] opcode_q;
    logic [4:0] exp_pc_q;
    logic [4:0] exp_pc_inc;
    logic       err_seq_q;
    logic       seq_mismatch;

    assign exp_pc_inc   = exp_pc_q + 5'd1;
    assign seq_mismatch = (state_q == S_CAPT) && (opcode_q != 2'b11) &&
                          (core_dbg[7:3] != exp_pc_inc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode_q  <= '0;
            exp_pc_q  <= '0;
            err_seq_q <= 1'b0;
        end else begin
            if (pop && head[7]) opcode_q <= head[1:0];
            // resynchronise to the observed PC, whatever the opcode
            if (state_q == S_CAPT) exp_pc_q <= core_dbg[7:3];
            if (clr_err)           err_seq_q <= 1'b0;
            else if (seq_mismatch) err_seq_q <= 1'b1;
        end
    end
    assign err_seq = err_seq_q;
`else
    assign err_seq = 1'b0;
`endif

    assign in_ready   = (count_q != FULL);
    assign busy       = (state_q != S_IDLE) || (count_q != '0);
    assign fifo_count = count_q;
    assign core_ui    = core_ui_q;
    assign core_uio   = core_uio_q;
    assign res_data   = res_data_q;
    assign res_rd     = res_rd_q;
    assign res_pc     = res_pc_q;
    assign res_valid  = res_valid_q;
    assign err_bit7   = err_bit7_q;

endmodule

// File: tb/tb_instr_stream_tx.sv
// Testbench for instr_stream_tx. A small stand-in core follows the two-phase
// byte load protocol, executes after the second byte and reports
// uo = imm (high byte), rd = instr[4:2], pc = count of executed instructions.
// A queue-based reference model predicts every result from the pushed
// instructions alone.
module tb_instr_stream_tx;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_instr;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  core_ui, core_uio, core_uo, core_dbg;
    logic [7:0]  res_data;
    logic [2:0]  res_rd;
    logic [4:0]  res_pc;
    logic        res_valid, busy;
    logic [2:0]  fifo_count;
    logic        clr_err, err_bit7, err_seq;

    always #5 clk = ~clk;

    instr_stream_tx #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_instr(in_instr), .in_valid(in_valid), .in_ready(in_ready),
        .core_ui(core_ui), .core_uio(core_uio),
        .core_uo(core_uo), .core_dbg(core_dbg),
        .res_data(res_data), .res_rd(res_rd), .res_pc(res_pc), .res_valid(res_valid),
        .busy(busy), .fifo_count(fifo_count),
        .clr_err(clr_err), .err_bit7(err_bit7), .err_seq(err_seq)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- stand-in core ----------------
    logic [1:0] ph;
    logic [7:0] lo_b, hi_b, stub_uo;
    logic [4:0] stub_pc;
    logic [2:0] stub_rd;
    logic [4:0] pc_jump = 5'd0;   // extra PC advance, used to provoke a sequence error

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph <= 2'd0; lo_b <= 8'h00; hi_b <= 8'h00;
            stub_uo <= 8'h00; stub_pc <= 5'd0; stub_rd <= 3'd0;
        end else begin
            case (ph)
                2'd0: if (core_ui[7]) begin lo_b <= core_ui; ph <= 2'd1; end
                2'd1: begin hi_b <= core_uio; ph <= 2'd2; end
                default: begin
                    stub_pc <= stub_pc + 5'd1 + pc_jump;
                    stub_uo <= hi_b;
                    stub_rd <= lo_b[4:2];
                    ph <= 2'd0;
                end
            endcase
        end
    end
    assign core_uo  = stub_uo;
    assign core_dbg = {stub_pc, stub_rd};

    // ---------------- reference model / scoreboard ----------------
    typedef struct packed {
        logic [7:0] data;
        logic [2:0] rd;
        logic [4:0] pc;
    } res_t;

    res_t exp_q[$];
    res_t e;
    logic [4:0] pc_model = 5'd0;
    int cyc = 0;
    int res_count = 0;
    int res_cycles[$];
    int max_count = 0;
    int ui7_run = 0;
    bit drop_seen = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            pc_model = 5'd0;
            ui7_run = 0;
        end else begin
            check_val("in_ready_vs_count", in_ready, (fifo_count != 3'd4));
            if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
            ui7_run = core_ui[7] ? ui7_run + 1 : 0;
            if (core_ui[7]) check_val("ui7_run_le2", (ui7_run > 2), 0);
            if (res_valid) begin
                res_count++;
                res_cycles.push_back(cyc);
                $display("[TB] result data=%02h rd=%0d pc=%0d", res_data, res_rd, res_pc);
                if (exp_q.size() == 0) begin
                    check_val("unexpected_res", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("res_data", res_data, e.data);
                    check_val("res_rd", res_rd, e.rd);
                    check_val("res_pc", res_pc, e.pc);
                end
            end
            if (in_valid && in_ready) begin
                if (in_instr[7]) begin
                    pc_model = pc_model + 5'd1 + pc_jump;
                    e = '{in_instr[15:8], in_instr[4:2], pc_model};
                    exp_q.push_back(e);
                end else begin
                    drop_seen = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic push(input logic [15:0] v);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_instr = v;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
        end
        if (!ok) check_val("push_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_results(input int target);
        int n;
        n = 0;
        while (res_count < target && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("result_wait", (res_count >= target), 1);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
    endtask

    int n;
    int rc0;
    logic [15:0] v;

    initial begin
        in_valid = 1'b0; in_instr = 16'h0; clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        check_val("rst_core_ui", core_ui, 0);
        check_val("rst_core_uio", core_uio, 0);
        check_val("rst_res_valid", res_valid, 0);
        check_val("rst_res", {res_data, res_rd, res_pc}, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_fifo_count", fifo_count, 0);
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_err_bit7", err_bit7, 0);
        check_val("rst_err_seq", err_seq, 0);

        // single ADDI r1 = r4 + 5
        push(16'h0585);
        check_val("busy_after_push", busy, 1);
        n = 0;
        while (core_ui == 8'h00 && n < 20) begin @(posedge clk); #1; n++; end
        check_val("pop_latency", n, 1);
        check_val("lo_ui", core_ui, 8'h85);
        check_val("lo_uio", core_uio, 8'h00);
        @(posedge clk); #1;
        check_val("hi_ui", core_ui, 8'h80);
        check_val("hi_uio", core_uio, 8'h05);
        @(posedge clk); #1;
        check_val("exec_ui", core_ui, 8'h00);
        @(posedge clk); #1;
        check_val("capt_ui", core_ui, 8'h00);
        check_val("capt_res_valid", res_valid, 0);
        @(posedge clk); #1;
        check_val("addi_res_valid", res_valid, 1);
        check_val("addi_res_data", res_data, 8'h05);
        check_val("addi_res_rd", res_rd, 1);
        check_val("addi_res_pc", res_pc, 1);
        @(posedge clk); #1;
        check_val("res_valid_pulse", res_valid, 0);

        // dropped instruction (bit 7 clear)
        rc0 = res_count;
        push(16'h0505);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check_val("drop_core_ui", core_ui, 0);
        end
        check_val("drop_err_bit7", err_bit7, 1);
        check_val("drop_no_result", res_count, rc0);
        pulse_clr();
        check_val("clr_err_bit7", err_bit7, 0);

        // clear in the same cycle as a drop: clear wins
        push(16'h0505);
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        check_val("clr_priority", err_bit7, 0);
        repeat (3) @(posedge clk); #1;
        check_val("clr_priority_hold", err_bit7, 0);
        drop_seen = 1'b0;

        // burst of 5 back-to-back instructions from reset
        do_reset();
        res_cycles.delete();
        max_count = 0;
        rc0 = res_count;
        for (int i = 0; i < 5; i++) begin
            v = 16'($urandom);
            v[7] = 1'b1;
            push(v);
        end
        wait_results(rc0 + 5);
        check_val("burst_max_count", max_count, 4);
        for (int i = 1; i < 5 && i < res_cycles.size(); i++)
            check_val("burst_spacing", res_cycles[i] - res_cycles[i-1], 5);

        // reset during the HI cycle aborts the instruction
        push(16'h0585);
        push(16'h0a8d);
        n = 0;
        while (core_ui != 8'h80 && n < 20) begin @(posedge clk); #1; n++; end
        check_val("reach_hi", core_ui, 8'h80);
        rst = 1'b1;
        #1;
        check_val("abort_core_ui", core_ui, 0);
        check_val("abort_fifo_count", fifo_count, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        rc0 = res_count;
        repeat (8) @(posedge clk); #1;
        check_val("abort_no_result", res_count, rc0);
        push(16'h0585);
        wait_results(rc0 + 1);
        check_val("repush_pc", res_pc, 1);
        check_val("repush_data", res_data, 8'h05);

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            v = 16'($urandom);
            v[7] = ($urandom_range(0, 4) != 0);
            push(v);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 600) begin @(posedge clk); #1; n++; end
        check_val("drain_done", (exp_q.size() == 0 && !busy), 1);
        check_val("drain_fifo_count", fifo_count, 0);
        check_val("random_err_bit7", err_bit7, drop_seen);
        check_val("err_seq_quiet", err_seq, 0);

`ifdef SEQ_CHECK_EN
        // PC jumps to 3 on the first instruction after reset: sequence error
        do_reset();
        pc_jump = 5'd2;
        rc0 = res_count;
        push(16'h0080);
        wait_results(rc0 + 1);
        pc_jump = 5'd0;
        check_val("seq_jump_pc", res_pc, 3);
        check_val("seq_err_set", err_seq, 1);
        pulse_clr();
        check_val("seq_err_clr", err_seq, 0);
        push(16'h0080);
        wait_results(rc0 + 2);
        @(posedge clk); #1;
        check_val("seq_next_pc", res_pc, 4);
        check_val("seq_no_new_err", err_seq, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
